// File: rtl/ram_fifo_pkg.sv
// Shared types and helpers for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_t;

    function automatic int depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Turns an external single-port synchronous RAM (1-cycle read latency) into a
// FIFO with a registered head word; one RAM access per cycle, reads first.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    // Handshake rule on both sides: a word moves on a rising edge exactly when
    // valid && ready are both high in the preceding cycle; valid never waits on ready.

    localparam int                DEPTH   = depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    rd_state_t             state;
    rd_state_t             state_next;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  fetch;
    logic                  push;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0) && !out_valid && (state == RD_IDLE);

    always_comb begin
        state_next = state;
        fetch      = 1'b0;
        if (!rst && state == RD_IDLE && count != '0 && (!out_valid || out_ready)) begin
            fetch = 1'b1;
        end
        case (state)
            RD_IDLE: if (fetch) state_next = RD_WAIT;
            RD_WAIT: state_next = RD_IDLE;
            default: state_next = RD_IDLE;
        endcase
    end

    // A fetch steals the RAM port, so a push in the same cycle must wait.
    assign in_ready = !rst && !full && !fetch;
    assign push     = in_valid && in_ready;
    assign ram_addr = fetch ? rd_ptr : wr_ptr;
    assign ram_we   = push;
    assign ram_data = in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RD_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
            end else if (fetch) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count - CNT_ONE;
            end
            // out_valid is always 0 in RD_WAIT, so a load never meets a pop.
            if (state == RD_WAIT) begin
                out_data  <= ram_q;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Upstream controller for the team's single-port synchronous RAM (ports addr, clk, q, we, data; parameters DATA_WIDTH, ADDR_WIDTH).
- Turns the RAM into a first-in-first-out queue with valid/ready push and pop interfaces.
- Drives the RAM addr/we/data ports directly and consumes q.
- The RAM is instantiated beside this block in the parent; this block does not contain it.

Parameters:
DATA_WIDTH, 8, width of queued words; equals the RAM DATA_WIDTH
ADDR_WIDTH, 8, RAM address width; RAM storage depth DEPTH = 2**ADDR_WIDTH

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  push request
in_ready  out  1  push accepted when in_valid && in_ready
in_data  in  DATA_WIDTH  push word
out_valid  out  1  output register holds a word
out_ready  in  1  consumer takes word when out_valid && out_ready
out_data  out  DATA_WIDTH  head word
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_we  out  1  to RAM we
ram_data  out  DATA_WIDTH  to RAM data
ram_q  in  DATA_WIDTH  from RAM q; valid the cycle after an address is presented (1-cycle read latency)
count  out  ADDR_WIDTH+1  words held in RAM, excluding the read in flight and the output register
full  out  1  count == DEPTH
empty  out  1  count == 0 && out_valid == 0 && no read in flight

Behaviour:
- State: wr_ptr and rd_ptr (ADDR_WIDTH bits each, wrap naturally modulo DEPTH), count, read FSM, out_data/out_valid register.
- Reset, synchronous on rst=1: pointers=0, count=0, FSM=RD_IDLE, out_valid=0, out_data=0.
- During reset cycles: in_ready=0, ram_we=0.
- Read FSM:
  - RD_IDLE -> RD_WAIT when fetch=1.
  - fetch = !rst && FSM==RD_IDLE && count!=0 && (!out_valid || out_ready).
  - RD_WAIT -> RD_IDLE unconditionally after one cycle; in that cycle out_data<=ram_q and out_valid<=1.
- One RAM access per cycle; read has priority.
  - in_ready = !rst && !full && !fetch. Combinational, may depend on out_ready.
  - ram_addr = fetch ? rd_ptr : wr_ptr.
  - ram_we = in_valid && in_ready.
  - ram_data = in_data.
- Pointer and count updates:
  - Push accepted: wr_ptr+1, count+1.
  - fetch: rd_ptr+1, count-1.
  - The two never occur in the same cycle.
- Pop handshake:
  - out_valid && out_ready with no load that cycle: out_valid<=0.
  - A pop and a RAM load in the same cycle cannot occur: out_valid is 0 during RD_WAIT by construction.
- Latency and throughput:
  - Push into an empty queue gives out_valid 3 cycles after the accepting edge: write edge, fetch edge, load edge.
  - Sustained pop rate is 1 word per 2 cycles.
  - Pushes proceed in every cycle without a fetch.
- Full: in_ready=0 while count==DEPTH. Total capacity is DEPTH+1 words including the output register.
- Wrap: pointer wrap from DEPTH-1 to 0 needs no special handling.
- Read-after-write: a word written at edge t is fetched no earlier than edge t+1, so no RAM read-during-write collision is possible.
- Reset mid-operation: a pending RD_WAIT is abandoned, ram_q is ignored, and all contents are discarded.
- out_data holds its value while out_valid=0.

Decomposition:
- Package ram_fifo_pkg holds:
  - enum rd_state_t {RD_IDLE, RD_WAIT}
  - function depth(ADDR_WIDTH) returning 2**ADDR_WIDTH
- No sub-module: the controller is a single module.
- The parent wires ram_* to RAM addr/we/data/q.
- The bench instantiates ram_fifo_ctrl together with RAM.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, in_ready=0 during reset, count=0, empty=1, ram_we=0; after release in_ready=1.
- Single word: push 8'hA5 once, out_ready=1 -> ram_we=1 with ram_addr=0 on that cycle; out_valid=1 with out_data=8'hA5 exactly 3 cycles later; then empty=1.
- Order and wrap, ADDR_WIDTH=2: push 10 words 1..10, popping as they arrive with out_ready=1 -> output sequence 1..10 in order; wr_ptr and rd_ptr wrap past 3.
- Full, ADDR_WIDTH=2, out_ready=0: push 6 words 8'h10..8'h15 -> 8'h10 lands in the output register; 8'h11..8'h14 fill the RAM (count=4, full=1); in_ready=0 and 8'h15 held. Raise out_ready -> 8'h15 accepted once count drops to 3.
- Priority collision: count=2, out_valid=1, out_ready=1, in_valid=1 -> that cycle in_ready=0, ram_addr=rd_ptr, ram_we=0; push accepted the following cycle.
- Reset mid-read: assert rst in the RD_WAIT cycle -> next cycle out_valid=0, count=0; the stale ram_q is never presented.
